adder_subtractor_overflow: RTL and testbench
============================================

# adder_subtractor_overflow

Parameterised n-bit two's-complement adder/subtractor with carry-out and signed-overflow detection, built as a ripple chain of full adders with registered outputs. A single mode bit selects addition or subtraction. Results appear one clock after a valid operand pair is presented. The block is the arithmetic leaf used by the Full_Adder datapath and its simulations.

## Interface
- n, default 4, operand/result width in bits (n ≥ 2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- x  input  n  operand A (unsigned or two's complement)
- y  input  n  operand B
- add_n  input  1  mode: 0 = add (x + y), 1 = subtract (x − y)
- in_valid  input  1  operands and mode are sampled on a clk edge where this is high
- s  output  n  registered result, low n bits
- c_out  output  1  registered carry out of bit n−1
- overflow  output  1  registered signed-overflow flag
- out_valid  output  1  high for one cycle when s/c_out/overflow carry a new result
- One clock; reset is synchronous and active-high.

## Operation
- Datapath: n full adders chained ripple-style; each stage computes sum = a ^ b ^ ci and co = a&b | a&ci | b&ci.
- Operand B for stage i is y[i] ^ add_n; carry into stage 0 is add_n. Subtraction is therefore x + ~y + 1.
- c_n = carry out of stage n−1; c_(n−1) = carry into stage n−1.
- c_out = c_n. In subtract mode c_out = 1 means no borrow (x ≥ y unsigned).
- overflow = c_n ^ c_(n−1): set when the two's-complement result does not fit in n bits. It is meaningful only for signed interpretation; c_out is the unsigned indicator.
- All arithmetic is modulo 2^n; s wraps with no saturation.
- x, y and add_n have equal priority and are all sampled together. Mode changes take effect on the next sampled operation only.

## Timing
- Latency: 1 cycle. On a rising clk edge with in_valid = 1, s, c_out and overflow load the combinational result of the sampled inputs, and out_valid is set to 1.
- On an edge with in_valid = 0: s, c_out and overflow hold their previous values, and out_valid is set to 0.
- Back-to-back operation: a new operation is accepted every cycle with full throughput and no stall. There is no backpressure.
- Reset: on an edge with rst = 1, s = 0, c_out = 0, overflow = 0 and out_valid = 0. Reset overrides in_valid in the same cycle. An operation presented during reset is discarded and never produces out_valid.
- Reset mid-stream: a result already registered is cleared. Sampling resumes on the first edge with rst = 0.
- The combinational ripple path from x/y/add_n to the output registers is the critical path; no intermediate pipelining.

## Test plan
Values below use n = 4.
- Reset: assert rst for 2 cycles with in_valid = 1, x = 5, y = 6 -> s = 0, c_out = 0, overflow = 0 and out_valid = 0 throughout and on the first cycle after release.
- Add then subtract back-to-back: x = 5, y = 6, add_n = 0, then add_n = 1 on the next cycle, in_valid = 1.
  - First result: s = 4'b1011 (11), c_out = 0, overflow = 1.
  - Second result, one cycle later: s = 4'b1111 (−1), c_out = 0, overflow = 0.
  - out_valid stays high for both cycles.
- Boundaries:
  - 7 + 1 -> s = 4'b1000, c_out = 0, overflow = 1.
  - 15 + 1 -> s = 0, c_out = 1, overflow = 0.
  - 8 − 1 (−8 − 1) -> s = 4'b0111, c_out = 1, overflow = 1.
  - 3 − 3 -> s = 0, c_out = 1, overflow = 0.
- Hold: after a valid op, drop in_valid and change x/y/add_n -> outputs unchanged, out_valid = 0.
- Mid-stream reset: stream ops with in_valid = 1, pulse rst for one cycle -> outputs are 0 the cycle after the pulse, and the operation presented during reset never appears.
- Exhaustive: for n = 4, all 512 (x, y, add_n) combinations -> each result checked one cycle later against a reference model.
  - s = (x ± y) mod 16.
  - c_out = bit 4 of x + (y ^ {4{add_n}}) + add_n.
  - overflow = signed result outside −8..7.

Source files
------------

// File: rtl/adder_subtractor_overflow.sv
// n-bit two's-complement adder/subtractor built as a ripple chain of full adders.
// Result, carry-out and signed-overflow are registered one clock after in_valid.
module adder_subtractor_overflow #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [n-1:0] x,
    input  logic [n-1:0] y,
    input  logic         add_n,
    input  logic         in_valid,
    output logic [n-1:0] s,
    output logic         c_out,
    output logic         overflow,
    output logic         out_valid
);

    logic [n-1:0] b_op;
    logic [n-1:0] sum;
    logic         carry_msb_in;
    logic         carry_msb_out;

    // Subtraction is x + ~y + 1: invert operand B and inject add_n as carry-in.
    assign b_op = y ^ {n{add_n}};

    always_comb begin
        logic carry;
        sum          = '0;
        carry_msb_in = 1'b0;
        // NOTE: blocking assignments here let 'carry' ripple stage to stage within one
        // evaluation; registers below use non-blocking so every flop samples pre-edge values.
        carry = add_n;
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) begin
                carry_msb_in = carry;
            end
            sum[i] = x[i] ^ b_op[i] ^ carry;
            carry  = (x[i] & b_op[i]) | (x[i] & carry) | (b_op[i] & carry);
        end
        carry_msb_out = carry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s         <= '0;
            c_out     <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                s        <= sum;
                c_out    <= carry_msb_out;
                overflow <= carry_msb_out ^ carry_msb_in;
            end
        end
    end

endmodule

// File: tb/tb_adder_subtractor_overflow.sv
// Self-checking bench: every driven cycle pushes the expected registered outputs to a
// scoreboard that a negedge monitor pops; scenario tasks add direct constant checks.
module tb_adder_subtractor_overflow;

    localparam int N = 4;

    typedef struct packed {
        logic         v;
        logic [N-1:0] s;
        logic         c;
        logic         ov;
    } result_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         add_n;
    logic         in_valid;
    logic [N-1:0] s;
    logic         c_out;
    logic         overflow;
    logic         out_valid;

    result_t sb[$];
    result_t model_state = '0;
    int      total  = 0;
    int      passed = 0;

    adder_subtractor_overflow #(.n(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .y         (y),
        .add_n     (add_n),
        .in_valid  (in_valid),
        .s         (s),
        .c_out     (c_out),
        .overflow  (overflow),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Reference arithmetic: unsigned sum for s/c_out, signed integer range for overflow.
    function automatic result_t reference(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic m);
        result_t      r;
        logic [N-1:0] bi;
        int           full;
        int           sa;
        int           sb_i;
        int           signed_res;
        bi         = m ? ~b : b;
        full       = int'(a) + int'(bi) + int'(m);
        sa         = int'($signed(a));
        sb_i       = int'($signed(b));
        signed_res = m ? (sa - sb_i) : (sa + sb_i);
        r.v        = 1'b1;
        r.s        = full[N-1:0];
        r.c        = full[N];
        r.ov       = (signed_res < -(2 ** (N - 1))) || (signed_res > (2 ** (N - 1)) - 1);
        return r;
    endfunction

    // Drive one cycle, push the expected post-edge outputs, return at posedge + 1.
    task automatic drive(input logic r, input logic v, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic m);
        rst      = r;
        in_valid = v;
        x        = a;
        y        = b;
        add_n    = m;
        if (r) begin
            model_state = '0;
        end else if (v) begin
            model_state = reference(a, b, m);
        end else begin
            model_state.v = 1'b0;
        end
        sb.push_back(model_state);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            result_t exp_r;
            exp_r = sb.pop_front();
            total++;
            if ({out_valid, s, c_out, overflow} !== exp_r) begin
                $display("FAIL scoreboard t=%0t: got v=%b s=%h c=%b ov=%b, expected v=%b s=%h c=%b ov=%b",
                         $time, out_valid, s, c_out, overflow, exp_r.v, exp_r.s, exp_r.c, exp_r.ov);
            end else begin
                passed++;
            end
        end
    end

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 4'd5, 4'd6, 1'b0);
            total++;
            if ({out_valid, s, c_out, overflow} !== 7'b0) begin
                $display("FAIL reset_hold cycle %0d: got v=%b s=%h c=%b ov=%b, expected all 0",
                         i, out_valid, s, c_out, overflow);
            end else begin
                passed++;
            end
        end
        drive(1'b0, 1'b0, 4'd5, 4'd6, 1'b0);
        total++;
        if ({out_valid, s, c_out, overflow} !== 7'b0) begin
            $display("FAIL reset_release: got v=%b s=%h c=%b ov=%b, expected all 0",
                     out_valid, s, c_out, overflow);
        end else begin
            passed++;
        end
    endtask

    task automatic test_add_sub_back_to_back();
        drive(1'b0, 1'b1, 4'd5, 4'd6, 1'b0);
        total++;
        if ({out_valid, s, c_out, overflow} !== {1'b1, 4'b1011, 1'b0, 1'b1}) begin
            $display("FAIL add_5_6: got v=%b s=%h c=%b ov=%b, expected v=1 s=b c=0 ov=1",
                     out_valid, s, c_out, overflow);
        end else begin
            passed++;
        end
        drive(1'b0, 1'b1, 4'd5, 4'd6, 1'b1);
        total++;
        if ({out_valid, s, c_out, overflow} !== {1'b1, 4'b1111, 1'b0, 1'b0}) begin
            $display("FAIL sub_5_6: got v=%b s=%h c=%b ov=%b, expected v=1 s=f c=0 ov=0",
                     out_valid, s, c_out, overflow);
        end else begin
            passed++;
        end
    endtask

    task automatic test_boundaries();
        logic [N-1:0] xs[4];
        logic [N-1:0] ys[4];
        logic         ms[4];
        logic [N-1:0] es[4];
        logic         ec[4];
        logic         eo[4];
        xs = '{4'd7, 4'd15, 4'd8, 4'd3};
        ys = '{4'd1, 4'd1,  4'd1, 4'd3};
        ms = '{1'b0, 1'b0,  1'b1, 1'b1};
        es = '{4'b1000, 4'b0000, 4'b0111, 4'b0000};
        ec = '{1'b0, 1'b1, 1'b1, 1'b1};
        eo = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, xs[i], ys[i], ms[i]);
            total++;
            if ({out_valid, s, c_out, overflow} !== {1'b1, es[i], ec[i], eo[i]}) begin
                $display("FAIL boundary_%0d: got v=%b s=%h c=%b ov=%b, expected v=1 s=%h c=%b ov=%b",
                         i, out_valid, s, c_out, overflow, es[i], ec[i], eo[i]);
            end else begin
                passed++;
            end
        end
    endtask

    task automatic test_hold();
        drive(1'b0, 1'b1, 4'd2, 4'd9, 1'b0);
        drive(1'b0, 1'b0, 4'd14, 4'd3, 1'b1);
        total++;
        if ({out_valid, s, c_out, overflow} !== {1'b0, 4'b1011, 1'b0, 1'b0}) begin
            $display("FAIL hold: got v=%b s=%h c=%b ov=%b, expected v=0 s=b c=0 ov=0",
                     out_valid, s, c_out, overflow);
        end else begin
            passed++;
        end
    endtask

    task automatic test_mid_stream_reset();
        drive(1'b0, 1'b1, 4'd6, 4'd7, 1'b0);
        drive(1'b0, 1'b1, 4'd9, 4'd4, 1'b1);
        drive(1'b1, 1'b1, 4'd7, 4'd7, 1'b0);
        total++;
        if ({out_valid, s, c_out, overflow} !== 7'b0) begin
            $display("FAIL mid_reset: got v=%b s=%h c=%b ov=%b, expected all 0",
                     out_valid, s, c_out, overflow);
        end else begin
            passed++;
        end
        drive(1'b0, 1'b0, 4'd7, 4'd7, 1'b0);
        total++;
        if ({out_valid, s, c_out, overflow} !== 7'b0) begin
            $display("FAIL mid_reset_discard: got v=%b s=%h c=%b ov=%b, expected all 0",
                     out_valid, s, c_out, overflow);
        end else begin
            passed++;
        end
        drive(1'b0, 1'b1, 4'd1, 4'd2, 1'b0);
    endtask

    task automatic test_exhaustive();
        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < 2 ** N; a++) begin
                for (int b = 0; b < 2 ** N; b++) begin
                    drive(1'b0, 1'b1, N'(a), N'(b), m[0]);
                end
            end
        end
        drive(1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        x        = '0;
        y        = '0;
        add_n    = 1'b0;
        test_reset();
        test_add_sub_back_to_back();
        test_boundaries();
        test_hold();
        test_mid_stream_reset();
        test_exhaustive();
        @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end else begin
            passed++;
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
